// File: rtl/clarke_xform_pipe_if.sv
// Stream bundle for the Clarke stage: abc sample in, alpha/beta out, sat status.
// Latency: n/a (signal bundle only, no logic).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready handshakes.
//
// Ports / signals:
//   in_valid, in_ready, in_mode, a, b, c      - upstream sample handshake and data
//   out_valid, out_ready, alpha, beta, out_sat - downstream result handshake and data
//   sat_sticky, sat_clr                        - saturation status and its clear
// Modports: master = producer/consumer side (bench or neighbour stages),
//           slave  = the transform block itself.
interface clarke_xform_pipe_if #(
    parameter int DW = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic signed [DW-1:0] c;

    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] alpha;
    logic signed [DW-1:0] beta;
    logic                 out_sat;

    logic                 sat_sticky;
    logic                 sat_clr;

    modport master (
        output in_valid, in_mode, a, b, c, out_ready, sat_clr,
        input  in_ready, out_valid, alpha, beta, out_sat, sat_sticky
    );

    modport slave (
        input  in_valid, in_mode, a, b, c, out_ready, sat_clr,
        output in_ready, out_valid, alpha, beta, out_sat, sat_sticky
    );
endinterface

// File: rtl/clarke_xform_pipe.sv
// Pipelined Clarke (abc -> alpha/beta) transform, 2- or 3-phase per sample, rounded and saturated.
// Latency: 3 cycles input handshake to out_valid; throughput 1 sample/cycle.
// Backpressure: full valid/ready; each stage holds when blocked, bubbles collapse, in_ready low only when S1..S3 all full and S3 stalled.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous reset, active-high
//   bus        - clarke_xform_pipe_if.slave: in_valid/in_ready/in_mode/a/b/c,
//                out_valid/out_ready/alpha/beta/out_sat, sat_sticky/sat_clr
module clarke_xform_pipe #(
    parameter int DW      = 16,
    parameter int CF      = 15,
    parameter int K_ISQ3  = $rtoi((2.0 ** CF) / 1.7320508075688772 + 0.5),
    parameter int K_THIRD = ((1 << CF) + 1) / 3
) (
    input  logic                    clk,
    input  logic                    rst,
    clarke_xform_pipe_if.slave      bus
);

    // Sum width holds 2a - b - c without overflow; product width holds sum * coefficient.
    localparam int SW = DW + 2;
    localparam int PW = DW + CF + 3;

    localparam logic signed [PW-1:0] C_ISQ3  = PW'(K_ISQ3);
    localparam logic signed [PW-1:0] C_THIRD = PW'(K_THIRD);
    localparam logic signed [PW-1:0] C_HALF  = PW'(64'd1 << (CF - 1));

    // Output range limits expressed at product-shifted width for direct comparison.
    localparam logic signed [PW-1:0] R_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] R_MIN = ~R_MAX;

    // ------------------------------------------------------------------
    // Stage handshake chain. Each stage may load when it is empty or when
    // its current content moves on in the same cycle. in_ready is derived
    // only from stage valids and out_ready, never from in_valid.
    // ------------------------------------------------------------------
    logic r1_v;
    logic r2_v;
    logic r3_v;

    logic w_s3_adv;
    logic w_s3_en;
    logic w_s2_adv;
    logic w_s2_en;
    logic w_s1_adv;
    logic w_s1_en;
    logic w_in_xfer;
    logic w_out_xfer;

    assign w_s3_adv   = r3_v & bus.out_ready;
    assign w_s3_en    = ~r3_v | w_s3_adv;
    assign w_s2_adv   = r2_v & w_s3_en;
    assign w_s2_en    = ~r2_v | w_s2_adv;
    assign w_s1_adv   = r1_v & w_s2_en;
    assign w_s1_en    = ~r1_v | w_s1_adv;
    assign w_in_xfer  = bus.in_valid & w_s1_en;
    assign w_out_xfer = w_s3_adv;

    assign bus.in_ready = w_s1_en;

    // ------------------------------------------------------------------
    // S1: phase sums. Both results are pre-scaled so that S2 only needs a
    // single coefficient per channel:
    //   2-phase: alpha = a,            beta = (a + 2b) / sqrt3
    //   3-phase: alpha = (2a-b-c) / 3, beta = (b - c)  / sqrt3
    // ------------------------------------------------------------------
    logic signed [SW-1:0] w_a_x;
    logic signed [SW-1:0] w_b_x;
    logic signed [SW-1:0] w_c_x;
    logic signed [SW-1:0] w_sa;
    logic signed [SW-1:0] w_sb;

    assign w_a_x = {{2{bus.a[DW-1]}}, bus.a};
    assign w_b_x = {{2{bus.b[DW-1]}}, bus.b};
    assign w_c_x = {{2{bus.c[DW-1]}}, bus.c};

    always_comb begin
        w_sa = w_a_x;
        w_sb = w_a_x + (w_b_x <<< 1);
        if (bus.in_mode) begin
            w_sa = (w_a_x <<< 1) - w_b_x - w_c_x;
            w_sb = w_b_x - w_c_x;
        end
    end

    logic                 r1_mode;
    logic signed [SW-1:0] r1_sa;
    logic signed [SW-1:0] r1_sb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_v    <= 1'b0;
            r1_mode <= 1'b0;
            r1_sa   <= '0;
            r1_sb   <= '0;
        end else begin
            if (w_s1_en) begin
                r1_v <= w_in_xfer;
            end
            // Data registers only move on a real transfer so that idle-bus
            // values never reach state.
            if (w_in_xfer) begin
                r1_mode <= bus.in_mode;
                r1_sa   <= w_sa;
                r1_sb   <= w_sb;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: full-precision products. In 2-phase mode alpha is a pure shift so
    // that the round step in S3 returns a exactly.
    // ------------------------------------------------------------------
    logic signed [PW-1:0] w_sa_p;
    logic signed [PW-1:0] w_sb_p;
    logic signed [PW-1:0] w_pa;
    logic signed [PW-1:0] w_pb;

    assign w_sa_p = {{(PW-SW){r1_sa[SW-1]}}, r1_sa};
    assign w_sb_p = {{(PW-SW){r1_sb[SW-1]}}, r1_sb};

    always_comb begin
        w_pa = w_sa_p <<< CF;
        if (r1_mode) begin
            w_pa = w_sa_p * C_THIRD;
        end
        w_pb = w_sb_p * C_ISQ3;
    end

    logic signed [PW-1:0] r2_pa;
    logic signed [PW-1:0] r2_pb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_v  <= 1'b0;
            r2_pa <= '0;
            r2_pb <= '0;
        end else begin
            if (w_s2_en) begin
                r2_v <= r1_v;
            end
            if (w_s1_adv) begin
                r2_pa <= w_pa;
                r2_pb <= w_pb;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: round half up (add half LSB, arithmetic shift = floor), then clamp.
    // Returned word is {saturated, value}.
    // ------------------------------------------------------------------
    function automatic logic [DW:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        logic [DW:0]          res;
        r = (p + C_HALF) >>> CF;
        if (r > R_MAX) begin
            res = {1'b1, 1'b0, {(DW-1){1'b1}}};
        end else if (r < R_MIN) begin
            res = {1'b1, 1'b1, {(DW-1){1'b0}}};
        end else begin
            res = {1'b0, r[DW-1:0]};
        end
        round_sat = res;
    endfunction

    logic [DW:0] w_ra;
    logic [DW:0] w_rb;

    assign w_ra = round_sat(r2_pa);
    assign w_rb = round_sat(r2_pb);

    logic signed [DW-1:0] r3_alpha;
    logic signed [DW-1:0] r3_beta;
    logic                 r3_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_v     <= 1'b0;
            r3_alpha <= '0;
            r3_beta  <= '0;
            r3_sat   <= 1'b0;
        end else begin
            if (w_s3_en) begin
                r3_v <= r2_v;
            end
            // Output data only changes when a new sample lands, so a stalled
            // output stays stable under out_ready=0.
            if (w_s2_adv) begin
                r3_alpha <= w_ra[DW-1:0];
                r3_beta  <= w_rb[DW-1:0];
                r3_sat   <= w_ra[DW] | w_rb[DW];
            end
        end
    end

    assign bus.out_valid = r3_v;
    assign bus.alpha     = r3_alpha;
    assign bus.beta      = r3_beta;
    assign bus.out_sat   = r3_sat;

    // ------------------------------------------------------------------
    // Sticky saturation flag: set by a saturated output handshake, cleared
    // by sat_clr; a set in the same cycle as a clear takes priority.
    // ------------------------------------------------------------------
    logic r_sat_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_sticky <= 1'b0;
        end else if (w_out_xfer && r3_sat) begin
            r_sat_sticky <= 1'b1;
        end else if (bus.sat_clr) begin
            r_sat_sticky <= 1'b0;
        end
    end

    assign bus.sat_sticky = r_sat_sticky;

endmodule
